// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core and a DMA engine.
// The core has priority in the open state. A granted multi-beat DMA burst locks the port
// until its last beat. The optional starvation counter is compiled in by defining
// DMEM_ARB_STARVE_EN. It forces a DMA grant after MAX_WAIT consecutive denials.
module dmem_arbiter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   // core port
   input  logic            core_req_i,
   output logic            core_gnt_o,
   input  logic [XLEN-1:0] core_addr_i,
   input  logic [XLEN-1:0] core_wr_data_i,
   input  logic [3:0]      core_size_i,
   input  logic            core_read_i,
   input  logic            core_write_i,
   output logic            core_rvalid_o,
   // dma port
   input  logic            dma_req_i,
   input  logic            dma_last_i,
   output logic            dma_gnt_o,
   input  logic [XLEN-1:0] dma_addr_i,
   input  logic [XLEN-1:0] dma_wr_data_i,
   input  logic [3:0]      dma_size_i,
   input  logic            dma_read_i,
   input  logic            dma_write_i,
   output logic            dma_rvalid_o,
   // memory port
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wr_data_o,
   output logic [3:0]      mem_size_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   input  logic [XLEN-1:0] mem_rd_data_i,
   output logic [XLEN-1:0] rd_data_o,
   output logic            dma_lock_o
);

   typedef enum logic [0:0] {StOpen, StDmaLock} state_e;

   state_e state_d, state_q;
   logic   core_rvalid_d, core_rvalid_q;
   logic   dma_rvalid_d, dma_rvalid_q;
   logic   starve_hit;

   // A zero-width wait counter would be meaningless.
   if (MAX_WAIT < 1) begin : g_param_chk
      $error("dmem_arbiter: MAX_WAIT must be at least 1");
   end

`ifdef DMEM_ARB_STARVE_EN
   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
   localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);

   logic [CntW-1:0] wait_cnt_d, wait_cnt_q;

   // Count consecutive DMA denials. Saturate at MAX_WAIT.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dma_req_i || dma_gnt_o) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WaitMax) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign starve_hit = (wait_cnt_q == WaitMax);
`else
   assign starve_hit = 1'b0;
`endif

   // Grant decision and burst-lock next state.
   always_comb begin
      state_d    = state_q;
      core_gnt_o = 1'b0;
      dma_gnt_o  = 1'b0;
      unique case (state_q)
         StOpen: begin
            dma_gnt_o  = dma_req_i & (~core_req_i | starve_hit);
            core_gnt_o = core_req_i & ~(dma_req_i & starve_hit);
            if (dma_gnt_o && !dma_last_i) begin
               state_d = StDmaLock;
            end
         end
         StDmaLock: begin
            dma_gnt_o = dma_req_i;
            if (dma_gnt_o && dma_last_i) begin
               state_d = StOpen;
            end
         end
         default: state_d = StOpen;
      endcase
   end

   // Route the granted requester's fields to memory. Drive zeros when idle.
   always_comb begin
      mem_addr_o    = '0;
      mem_wr_data_o = '0;
      mem_size_o    = '0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      if (dma_gnt_o) begin
         mem_addr_o    = dma_addr_i;
         mem_wr_data_o = dma_wr_data_i;
         mem_size_o    = dma_size_i;
         mem_read_o    = dma_read_i;
         mem_write_o   = dma_write_i;
      end else if (core_gnt_o) begin
         mem_addr_o    = core_addr_i;
         mem_wr_data_o = core_wr_data_i;
         mem_size_o    = core_size_i;
         mem_read_o    = core_read_i;
         mem_write_o   = core_write_i;
      end
   end

   // Read data returns one cycle after an accepted read. Tag it with its owner.
   always_comb begin
      core_rvalid_d = core_gnt_o & core_read_i;
      dma_rvalid_d  = dma_gnt_o & dma_read_i;
   end

   // State and read-valid registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StOpen;
         core_rvalid_q <= 1'b0;
         dma_rvalid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_rvalid_q <= core_rvalid_d;
         dma_rvalid_q  <= dma_rvalid_d;
      end
   end

   assign core_rvalid_o = core_rvalid_q;
   assign dma_rvalid_o  = dma_rvalid_q;
   assign rd_data_o     = mem_rd_data_i;
   assign dma_lock_o    = (state_q == StDmaLock);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks for dmem_arbiter.
// The starvation checks are compiled only when DMEM_ARB_STARVE_EN is defined.
module tb_dmem_arbiter;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned MAX_WAIT = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            core_req_i, core_read_i, core_write_i;
   logic [XLEN-1:0] core_addr_i, core_wr_data_i;
   logic [3:0]      core_size_i;
   logic            dma_req_i, dma_last_i, dma_read_i, dma_write_i;
   logic [XLEN-1:0] dma_addr_i, dma_wr_data_i;
   logic [3:0]      dma_size_i;
   logic [XLEN-1:0] mem_rd_data_i;
   logic            core_gnt_o, core_rvalid_o, dma_gnt_o, dma_rvalid_o;
   logic [XLEN-1:0] mem_addr_o, mem_wr_data_o, rd_data_o;
   logic [3:0]      mem_size_o;
   logic            mem_read_o, mem_write_o, dma_lock_o;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_arbiter #(
      .XLEN     (XLEN),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .core_req_i     (core_req_i),
      .core_gnt_o     (core_gnt_o),
      .core_addr_i    (core_addr_i),
      .core_wr_data_i (core_wr_data_i),
      .core_size_i    (core_size_i),
      .core_read_i    (core_read_i),
      .core_write_i   (core_write_i),
      .core_rvalid_o  (core_rvalid_o),
      .dma_req_i      (dma_req_i),
      .dma_last_i     (dma_last_i),
      .dma_gnt_o      (dma_gnt_o),
      .dma_addr_i     (dma_addr_i),
      .dma_wr_data_i  (dma_wr_data_i),
      .dma_size_i     (dma_size_i),
      .dma_read_i     (dma_read_i),
      .dma_write_i    (dma_write_i),
      .dma_rvalid_o   (dma_rvalid_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wr_data_o  (mem_wr_data_o),
      .mem_size_o     (mem_size_o),
      .mem_read_o     (mem_read_o),
      .mem_write_o    (mem_write_o),
      .mem_rd_data_i  (mem_rd_data_i),
      .rd_data_o      (rd_data_o),
      .dma_lock_o     (dma_lock_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic core_drive(input logic req, input logic rd, input logic wr,
                             input logic [XLEN-1:0] addr);
      core_req_i     = req;
      core_read_i    = rd;
      core_write_i   = wr;
      core_addr_i    = addr;
      core_wr_data_i = addr ^ 32'h5555_0000;
      core_size_i    = 4'hf;
   endtask

   task automatic dma_drive(input logic req, input logic rd, input logic wr, input logic last,
                            input logic [XLEN-1:0] addr);
      dma_req_i     = req;
      dma_read_i    = rd;
      dma_write_i   = wr;
      dma_last_i    = last;
      dma_addr_i    = addr;
      dma_wr_data_i = addr ^ 32'haaaa_0000;
      dma_size_i    = 4'h3;
   endtask

   // Model state for the randomized phase.
   logic m_lock, m_cg, m_dg, m_sh, exp_crv, exp_drv;
   int   m_cnt;

   initial begin
      rst_ni        = 1'b0;
      mem_rd_data_i = '0;
      core_drive(1'b0, 1'b0, 1'b0, '0);
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #2;
      check("rst_lock", dma_lock_o, 0);
      check("rst_crv", core_rvalid_o, 0);
      check("rst_drv", dma_rvalid_o, 0);
      check("rst_idle_rd", mem_read_o, 0);
      // While held in reset, the combinational outputs arbitrate from the open state.
      core_drive(1'b1, 1'b1, 1'b0, 32'h44);
      #1;
      check("rst_comb_cgnt", core_gnt_o, 1);
      check("rst_comb_addr", mem_addr_o, 32'h44);
      core_drive(1'b0, 1'b0, 1'b0, '0);
      cycle();
      rst_ni = 1'b1;
      cycle();

      // Core read at 0x100 with the DMA idle.
      core_drive(1'b1, 1'b1, 1'b0, 32'h100);
      #1;
      check("cread_gnt", core_gnt_o, 1);
      check("cread_dgnt", dma_gnt_o, 0);
      check("cread_addr", mem_addr_o, 32'h100);
      check("cread_rd", mem_read_o, 1);
      check("cread_size", mem_size_o, 4'hf);
      cycle();
      core_drive(1'b0, 1'b0, 1'b0, '0);
      mem_rd_data_i = 32'hdead_beef;
      #1;
      check("cread_rvalid", core_rvalid_o, 1);
      check("cread_drvalid", dma_rvalid_o, 0);
      check("cread_data", rd_data_o, 32'hdead_beef);
      check("idle_addr", mem_addr_o, 0);
      check("idle_wdata", mem_wr_data_o, 0);
      check("idle_wr", mem_write_o, 0);
      cycle();
      check("cread_rvalid_drop", core_rvalid_o, 0);

      // Both request in the open state. The core wins while the wait counter is 0.
      core_drive(1'b1, 1'b0, 1'b1, 32'h200);
      dma_drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h800);
      #1;
      check("both_cgnt", core_gnt_o, 1);
      check("both_dgnt", dma_gnt_o, 0);
      check("both_addr", mem_addr_o, 32'h200);
      check("both_wr", mem_write_o, 1);
      check("both_wdata", mem_wr_data_o, 32'h5555_0200);
      cycle();
      check("both_no_crv", core_rvalid_o, 0);

      // A single last beat with the core idle leaves the arbiter open.
      core_drive(1'b0, 1'b0, 1'b0, '0);
      #1;
      check("single_dgnt", dma_gnt_o, 1);
      check("single_addr", mem_addr_o, 32'h800);
      check("single_size", mem_size_o, 4'h3);
      cycle();
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("single_lock", dma_lock_o, 0);
      check("single_drv", dma_rvalid_o, 1);
      cycle();

      // Four-beat burst. The core starts requesting after beat 1 is accepted.
      for (int b = 1; b <= 4; b++) begin
         dma_drive(1'b1, 1'b1, 1'b0, b == 4, 32'h1000 + 32'(b));
         if (b > 1) core_drive(1'b1, 1'b1, 1'b0, 32'h300);
         #1;
         check($sformatf("burst_dgnt%0d", b), dma_gnt_o, 1);
         check($sformatf("burst_cgnt%0d", b), core_gnt_o, 0);
         check($sformatf("burst_lock%0d", b), dma_lock_o, b > 1);
         check($sformatf("burst_addr%0d", b), mem_addr_o, 32'h1000 + 32'(b));
         cycle();
      end
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("burst_end_lock", dma_lock_o, 0);
      check("burst_end_cgnt", core_gnt_o, 1);
      check("burst_end_drv", dma_rvalid_o, 1);
      cycle();
      core_drive(1'b0, 1'b0, 1'b0, '0);

      // Lock holds while the DMA pauses mid-burst.
      dma_drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000);
      cycle();
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      core_drive(1'b1, 1'b1, 1'b0, 32'h400);
      #1;
      check("pause_cgnt", core_gnt_o, 0);
      check("pause_dgnt", dma_gnt_o, 0);
      check("pause_rd", mem_read_o, 0);
      cycle();
      check("pause_lock", dma_lock_o, 1);
      dma_drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h2004);
      #1;
      check("pause_last_dgnt", dma_gnt_o, 1);
      cycle();
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("pause_end_cgnt", core_gnt_o, 1);
      cycle();
      core_drive(1'b0, 1'b0, 1'b0, '0);
      cycle();

      // Reset after beat 2 of a 4-beat burst abandons the burst.
      for (int b = 1; b <= 2; b++) begin
         dma_drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h3000 + 32'(b));
         cycle();
      end
      check("mid_lock_pre", dma_lock_o, 1);
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      core_drive(1'b1, 1'b1, 1'b0, 32'h500);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_lock", dma_lock_o, 0);
      check("mid_rst_drv", dma_rvalid_o, 0);
      #1;
      rst_ni = 1'b1;
      #1;
      check("mid_rel_cgnt", core_gnt_o, 1);
      check("mid_rel_addr", mem_addr_o, 32'h500);
      cycle();
      check("mid_rel_crv", core_rvalid_o, 1);
      core_drive(1'b0, 1'b0, 1'b0, '0);
      cycle();

`ifdef DMEM_ARB_STARVE_EN
      // Continuous contention: 8 core grants, then a forced DMA grant on cycle 9.
      core_drive(1'b1, 1'b0, 1'b0, 32'h600);
      dma_drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000);
      for (int c = 1; c <= 10; c++) begin
         #1;
         check($sformatf("starve_cgnt%0d", c), core_gnt_o, c != 9);
         check($sformatf("starve_dgnt%0d", c), dma_gnt_o, c == 9);
         cycle();
      end
      core_drive(1'b0, 1'b0, 1'b0, '0);
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle();
`else
      // Strict core priority: the DMA stays denied under continuous contention.
      core_drive(1'b1, 1'b0, 1'b0, 32'h600);
      dma_drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000);
      for (int c = 1; c <= 12; c++) begin
         #1;
         check($sformatf("strict_dgnt%0d", c), dma_gnt_o, 0);
         cycle();
      end
      core_drive(1'b0, 1'b0, 1'b0, '0);
      dma_drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle();
`endif

      // Randomized traffic against a small reference model.
      m_lock  = 1'b0;
      m_cnt   = 0;
      exp_crv = 1'b0;
      exp_drv = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         core_drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom);
         dma_drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3) == 0, $urandom);
`ifdef DMEM_ARB_STARVE_EN
         m_sh = (m_cnt == MAX_WAIT);
`else
         m_sh = 1'b0;
`endif
         if (m_lock) begin
            m_dg = dma_req_i;
            m_cg = 1'b0;
         end else begin
            m_dg = dma_req_i & (~core_req_i | m_sh);
            m_cg = core_req_i & ~(dma_req_i & m_sh);
         end
         #1;
         check("rnd_excl", core_gnt_o & dma_gnt_o, 0);
         check("rnd_cgnt", core_gnt_o, m_cg);
         check("rnd_dgnt", dma_gnt_o, m_dg);
         check("rnd_lock", dma_lock_o, m_lock);
         exp_crv = m_cg & core_read_i;
         exp_drv = m_dg & dma_read_i;
         if (m_lock && m_dg && dma_last_i) m_lock = 1'b0;
         else if (!m_lock && m_dg && !dma_last_i) m_lock = 1'b1;
         if (!dma_req_i || m_dg) m_cnt = 0;
         else if (m_cnt < MAX_WAIT) m_cnt++;
         cycle();
         check("rnd_crv", core_rvalid_o, exp_crv);
         check("rnd_drv", dma_rvalid_o, exp_drv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
